// File: rtl/num_scan_pkg.sv
// Shared types and constants for the range-scan controller.
// State encoding, counter width, multiple-slice indices; mul_cnt is built only with NUM_SCAN_HIST_EN.
package num_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 5;
  localparam int N_MUL = 5;
  localparam int MUL_W = CNT_W * N_MUL;

  localparam int M2  = 0;
  localparam int M3  = 1;
  localparam int M5  = 2;
  localparam int M7  = 3;
  localparam int M11 = 4;

  function automatic int mul_lsb(input int idx);
    return idx * CNT_W;
  endfunction

endpackage

// File: rtl/num_scan_ctrl_classify.sv
// Combinational 4-bit prime/multiple classifier (zero is in no set).
// Ports: val in 4; is_prime out 1; mul out 5 (x2,x3,x5,x7,x11).
module num_classify
  import num_scan_pkg::*;
(
  input  logic [3:0]       val,
  output logic             is_prime,
  output logic [N_MUL-1:0] mul
);

  always_comb begin
    is_prime = val inside {4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
    mul      = '0;
    mul[M2]  = (val != 4'd0) && !val[0];
    mul[M3]  = val inside {4'd3, 4'd6, 4'd9, 4'd12, 4'd15};
    mul[M5]  = val inside {4'd5, 4'd10, 4'd15};
    mul[M7]  = val inside {4'd7, 4'd14};
    mul[M11] = (val == 4'd11);
  end

endmodule

// File: rtl/num_scan_ctrl.sv
// Range-scan controller: sweeps [lo,hi] through num_classify, accumulating results.
// Ports: clk, reset, start, abort, lo, hi in; busy, done, err, prime_cnt, last_prime,
// last_valid, mul_cnt out. Macro NUM_SCAN_HIST_EN builds the multiple counters.
module num_scan_ctrl
  import num_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       lo,
  input  logic [3:0]       hi,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] prime_cnt,
  output logic [3:0]       last_prime,
  output logic             last_valid,
  output logic [MUL_W-1:0] mul_cnt
);

  state_t           state;
  logic [3:0]       cur;
  logic [3:0]       hi_q;
  logic             is_prime;
  logic [N_MUL-1:0] mul;

  num_classify u_cls (
    .val      (cur),
    .is_prime (is_prime),
    .mul      (mul)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur        <= '0;
      hi_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      prime_cnt  <= '0;
      last_prime <= '0;
      last_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            hi_q       <= hi;
            cur        <= lo;
            prime_cnt  <= '0;
            last_prime <= '0;
            last_valid <= 1'b0;
            if (lo <= hi) begin
              state <= ST_SCAN;
              busy  <= 1'b1;
              err   <= 1'b0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          // abort drops the current value uncounted
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_prime) begin
              prime_cnt  <= prime_cnt + CNT_W'(1);
              last_prime <= cur;
              last_valid <= 1'b1;
            end
            // compare to hi so hi=15 ends without wrap
            if (cur == hi_q) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cur <= cur + 4'd1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NUM_SCAN_HIST_EN
  logic             accept;
  logic             eval;
  logic [MUL_W-1:0] mul_q;

  assign accept = (state == ST_IDLE) && start;
  assign eval   = (state == ST_SCAN) && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_q <= '0;
    end else if (accept) begin
      mul_q <= '0;
    end else if (eval) begin
      for (int i = 0; i < N_MUL; i++) begin
        if (mul[i]) begin
          mul_q[mul_lsb(i) +: CNT_W] <=
            mul_q[mul_lsb(i) +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign mul_cnt = mul_q;
`else
  logic unused_mul;

  assign unused_mul = ^mul;
  assign mul_cnt    = '0;
`endif

endmodule

// File: tb/tb_num_scan_ctrl.sv
// Self-checking bench for num_scan_ctrl.
// Scoreboarded directed scans: full range, single, error, abort, restart, reset.
module tb_num_scan_ctrl;
  import num_scan_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       lo = '0;
  logic [3:0]       hi = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] prime_cnt;
  logic [3:0]       last_prime;
  logic             last_valid;
  logic [MUL_W-1:0] mul_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  pc;
    logic [3:0]  lp;
    logic        lv;
    logic        er;
    logic [24:0] mc;
  } exp_t;

  exp_t sb[$];

  num_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .lo         (lo),
    .hi         (hi),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .prime_cnt  (prime_cnt),
    .last_prime (last_prime),
    .last_valid (last_valid),
    .mul_cnt    (mul_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  function automatic bit m_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d < v; d++)
      if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model(input int l, input int h,
                                 input int n_eval);
    exp_t e;
    int   pl[5] = '{2, 3, 5, 7, 11};
    e.pc = '0;
    e.lp = '0;
    e.lv = 1'b0;
    e.er = (l > h);
    e.mc = '0;
    for (int v = l; v < l + n_eval; v++) begin
      if (m_prime(v)) begin
        e.pc = e.pc + 5'd1;
        e.lp = 4'(v);
        e.lv = 1'b1;
      end
`ifdef NUM_SCAN_HIST_EN
      for (int i = 0; i < 5; i++)
        if (v != 0 && v % pl[i] == 0)
          e.mc[i*5 +: 5] = e.mc[i*5 +: 5] + 5'd1;
`endif
    end
    return e;
  endfunction

  task automatic check_results(input string tag);
    exp_t e;
    chk({tag, "_sb"}, (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_pc"}, prime_cnt, e.pc);
      chk({tag, "_lp"}, last_prime, e.lp);
      chk({tag, "_lv"}, last_valid, e.lv);
      chk({tag, "_err"}, err, e.er);
      chk({tag, "_mul"}, mul_cnt, e.mc);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_pc"}, prime_cnt, 5'd0);
    chk({tag, "_lp"}, last_prime, 4'd0);
    chk({tag, "_lv"}, last_valid, 1'b0);
    chk({tag, "_mul"}, mul_cnt, 25'd0);
  endtask

  task automatic run_scan(input logic [3:0] l, input logic [3:0] h,
                          input bit repulse, input string tag);
    int n;
    int dk;
    bit er;
    er = (l > h);
    n  = er ? 0 : int'(h) - int'(l) + 1;
    dk = er ? 1 : n + 1;
    sb.push_back(model(int'(l), int'(h), n));
    @(negedge clk);
    lo    = l;
    hi    = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= dk; k++) begin
      if (k > 1) @(negedge clk);
      chk({tag, "_busy"}, busy, (k < dk) && !er);
      chk({tag, "_done"}, done, (k == dk));
      if (k == dk) check_results(tag);
      if (repulse) start = (k == 5);
    end
    @(negedge clk);
    chk({tag, "_done_end"}, done, 1'b0);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int seen;

    repeat (2) @(negedge clk);
    check_idle_zero("rst");
    reset = 1'b0;

    run_scan(4'd0, 4'd15, 1'b0, "full");
    run_scan(4'd9, 4'd9, 1'b0, "single");
    run_scan(4'd12, 4'd3, 1'b0, "range_err");
    run_scan(4'd13, 4'd15, 1'b0, "top_end");

    sb.push_back(model(4, 10, 3));
    @(negedge clk);
    lo    = 4'd4;
    hi    = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk("abort_busy", busy, 1'b1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_low", busy, 1'b0);
    check_results("abort");
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_held_pc", prime_cnt, 5'd1);

    run_scan(4'd0, 4'd15, 1'b1, "repulse");

    @(negedge clk);
    lo    = 4'd0;
    hi    = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_pc", prime_cnt, 5'd2);
    #2 reset = 1'b1;
    #1 check_idle_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;

    run_scan(4'd0, 4'd15, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/num_scan_ctrl.md
# num_scan_ctrl

Sequencing controller for the 4-bit prime/multiple classifier. On a `start` request it sweeps an inclusive operand range [`lo`, `hi`] through the classifier, one value per clock. It accumulates the prime count and the largest prime found, then reports completion with a one-cycle `done` pulse. It sits between the lab top level (switches/buttons) and the combinational classifier, and owns all sequencing and accumulation state.

## Interface
Parameters:
- none

Ports:
- `clk` in 1 — single system clock, rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `start` in 1 — request a scan; sampled only in IDLE.
- `abort` in 1 — cancel a scan in progress; sampled only in SCAN.
- `lo` in 4 — first operand of the range; latched at start.
- `hi` in 4 — last operand of the range; latched at start.
- `busy` out 1 — high while in SCAN.
- `done` out 1 — one-cycle completion pulse.
- `err` out 1 — range error flag (`lo > hi`); valid with `done`, held until the next accepted start.
- `prime_cnt` out 5 — number of primes evaluated (0..16).
- `last_prime` out 4 — largest prime evaluated.
- `last_valid` out 1 — `last_prime` is meaningful.
- `mul_cnt` out 25 — five 5-bit multiple counters, [4:0]=×2, [9:5]=×3, [14:10]=×5, [19:15]=×7, [24:20]=×11.

## Operation
- Classifier, zero excluded from all sets:
  - prime = {2,3,5,7,11,13};
  - mul[0]=nonzero multiple of 2, mul[1] of 3, mul[2] of 5, mul[3] of 7, mul[4] of 11.
- States are IDLE, SCAN and DONE.
- IDLE:
  - On `start`, latch `lo`/`hi`, set `cur=lo`, and clear all counters, `err`, `last_prime` and `last_valid`.
  - If `lo<=hi` go to SCAN.
  - Otherwise set `err=1` and go to DONE.
- SCAN:
  - Each cycle, evaluate `cur`. If prime: `prime_cnt+=1`, `last_prime=cur`, `last_valid=1`. Ranges are ascending, so the last prime found is the largest.
  - Then, if `cur==hi` go to DONE; else `cur+=1`.
  - Termination compares against `hi`, never against overflow, so `hi=15` does not wrap.
  - `abort` has priority over evaluation: the current `cur` is not counted, and the next state is IDLE with no `done`. Partial counts are held.
- DONE: `done=1` for exactly this cycle, then go to IDLE.
- `start` in SCAN or DONE is ignored. `abort` in IDLE or DONE is ignored.
- Counter width of 5 bits suffices: at most 16 values are evaluated, so no saturation logic is needed.
- Results remain stable from `done` until the next accepted start.

## Timing
- Reset (asynchronous, immediate, also mid-scan):
  - state=IDLE;
  - `busy`=`done`=`err`=`last_valid`=0;
  - `prime_cnt`=0, `last_prime`=0, `mul_cnt`=0, `cur`=0.
- `start` accepted at edge T:
  - SCAN occupies cycles T+1..T+N, where N=`hi`−`lo`+1;
  - `busy` is high exactly over that interval;
  - `done` is high in cycle T+N+1.
- Error case: `done` and `err` are high in cycle T+1. `busy` never rises.
- All outputs are registered. The count for value `cur` is visible one cycle after `cur` is evaluated, so final counts are valid when `done` is high.
- Minimum start-to-start spacing is N+2 cycles. `start` held high continuously retriggers on the first IDLE cycle after DONE.

## Configuration
- Macro `NUM_SCAN_HIST_EN`.
- Defined: the five multiple counters are instantiated. Each increments in SCAN when its classifier bit is set for `cur`, and each is cleared at start, like `prime_cnt`.
- Undefined: no multiple counters are built. `mul_cnt` is tied to 0, and the port stays present so the interface is unchanged.

## Structure
- Shared package `num_scan_pkg` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_SCAN`=2'd1, `ST_DONE`=2'd2;
  - the counter width constant `CNT_W`=5;
  - the multiple-slice index constants.
- One sub-module, `num_classify`: combinational, 4-bit input, outputs `is_prime` and `mul[4:0]`, instantiated once on `cur`.
- The top-level `num_scan_ctrl` holds the FSM, `cur`, and the accumulators.

## Test plan
- `lo`=0, `hi`=15, pulse `start` at T:
  - `busy` high T+1..T+16;
  - `done` at T+17;
  - `prime_cnt`=6, `last_prime`=13, `last_valid`=1, `err`=0;
  - with `NUM_SCAN_HIST_EN`: ×2=7, ×3=5, ×5=3, ×7=2, ×11=1.
- `lo`=`hi`=9:
  - `done` at T+2;
  - `prime_cnt`=0, `last_valid`=0;
  - ×3 count=1 if enabled.
- `lo`=12, `hi`=3:
  - `done` and `err` high at T+1, `busy` never high;
  - all counts 0.
- `lo`=4, `hi`=10, `abort` asserted on the 4th SCAN cycle (`cur`=7):
  - `busy` low on the next cycle, `done` never pulses;
  - `prime_cnt`=1, `last_prime`=5.
- `start` re-pulsed mid-scan (0..15): ignored, and the results match scenario 1.
- `reset` asserted asynchronously mid-scan: all outputs are 0 before the next clock edge, and a subsequent start completes normally.
